// File: rtl/crc32_parallel_engine.sv
// Registered parallel CRC-32 engine (polynomial 0x04C11DB7, MSB-first).
// Folds 1..8 right-aligned 32-bit DWs per enabled cycle into the running
// CRC, or into a freshly loaded seed. Output is the raw register: no final
// XOR, no reflection and no byte swap. Those steps are applied downstream.
module crc32_parallel_engine #(
    parameter int DATA_WIDTH   = 256,
    parameter int LENGTH_WIDTH = 4,
    parameter int POLY_WIDTH   = 32
) (
    input  logic                    CRC_i_CLK,
    input  logic                    CRC_i_RST,
    input  logic [DATA_WIDTH-1:0]   CRC_i_Message,
    input  logic [LENGTH_WIDTH-1:0] CRC_i_Length,
    input  logic                    CRC_i_EN,
    input  logic [POLY_WIDTH-1:0]   CRC_i_Seed,
    input  logic                    CRC_i_Seed_Load,
    output logic [POLY_WIDTH-1:0]   CRC_o_CRC
);

    localparam int                    NUM_DW   = DATA_WIDTH / 32;
    localparam logic [POLY_WIDTH-1:0] POLY     = 32'h04C11DB7;
    localparam logic [LENGTH_WIDTH:0] NUM_DW_L = (LENGTH_WIDTH + 1)'(NUM_DW);

    logic [POLY_WIDTH-1:0]   crc_q;
    logic [POLY_WIDTH-1:0]   crc_d;
    logic [POLY_WIDTH-1:0]   start_crc;
    logic [POLY_WIDTH-1:0]   folded_crc;
    logic [LENGTH_WIDTH:0]   len_ext;
    logic [LENGTH_WIDTH:0]   len_eff;

    // Absorb one 32-bit DW, bit 31 first, exactly as the serial LFSR would.
    function automatic logic [POLY_WIDTH-1:0] fold_dw(
        input logic [POLY_WIDTH-1:0] crc_in,
        input logic [31:0]           dw
    );
        logic [POLY_WIDTH-1:0] c;
        logic                  fb;
        c = crc_in;
        for (int b = 31; b >= 0; b--) begin
            fb = c[POLY_WIDTH-1] ^ dw[b];
            c  = {c[POLY_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    // Clamp the DW count to the bus capacity.
    always_comb begin
        len_ext = {1'b0, CRC_i_Length};
        len_eff = (len_ext > NUM_DW_L) ? NUM_DW_L : len_ext;
    end

    // Fold the valid DWs, highest index first, so the first bit absorbed is
    // bit L*32-1 and the last is bit 0. DWs at or above L are skipped, which
    // makes the result a length-selected chain of the unrolled steps.
    always_comb begin
        start_crc  = CRC_i_Seed_Load ? CRC_i_Seed : crc_q;
        folded_crc = start_crc;
        for (int dw = NUM_DW - 1; dw >= 0; dw--) begin
            if ((LENGTH_WIDTH + 1)'(dw) < len_eff) begin
                folded_crc = fold_dw(folded_crc, CRC_i_Message[dw*32 +: 32]);
            end
        end
    end

    // Next-state selection: fold data, load seed only, or hold.
    always_comb begin
        crc_d = crc_q;
        if (CRC_i_EN) begin
            if (len_eff != '0) begin
                crc_d = folded_crc;
            end else if (CRC_i_Seed_Load) begin
                crc_d = CRC_i_Seed;
            end
        end
    end

    // CRC register; reset discards any partial message.
    always_ff @(posedge CRC_i_CLK) begin
        if (CRC_i_RST) begin
            crc_q <= '1;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign CRC_o_CRC = crc_q;

endmodule

// File: tb/tb_crc32_parallel_engine.sv
// Directed and randomized checks of crc32_parallel_engine against a
// bit-serial MSB-first LFSR reference model.
module tb_crc32_parallel_engine;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic         clk;
    logic         rst;
    logic [255:0] msg;
    logic [3:0]   len;
    logic         en;
    logic [31:0]  seed;
    logic         seed_load;
    logic [31:0]  crc_o;

    int          tests_run;
    int          fail_cnt;
    logic [31:0] model_crc;
    logic [31:0] saved_crc;

    crc32_parallel_engine #(
        .DATA_WIDTH  (256),
        .LENGTH_WIDTH(4),
        .POLY_WIDTH  (32)
    ) dut (
        .CRC_i_CLK      (clk),
        .CRC_i_RST      (rst),
        .CRC_i_Message  (msg),
        .CRC_i_Length   (len),
        .CRC_i_EN       (en),
        .CRC_i_Seed     (seed),
        .CRC_i_Seed_Load(seed_load),
        .CRC_o_CRC      (crc_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Serial reference: walk the valid bit stream from bit n*32-1 down to 0.
    function automatic logic [31:0] ref_fold(input logic [31:0] start,
                                             input logic [255:0] m,
                                             input int unsigned l);
        logic [31:0] c;
        logic        fb;
        int          n;
        c = start;
        n = (l > 8) ? 8 : int'(l);
        for (int b = n * 32 - 1; b >= 0; b--) begin
            fb = c[31] ^ m[b];
            c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
        end
        return c;
    endfunction

    function automatic logic [255:0] rand_msg();
        logic [255:0] m;
        for (int i = 0; i < 8; i++) m[i*32 +: 32] = $urandom();
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_crc = 32'hFFFF_FFFF;
        check(tag, crc_o, model_crc);
    endtask

    // One clock with the given inputs; model update follows the spec rules.
    task automatic cyc(input logic e, input logic sl, input logic [31:0] s,
                       input logic [3:0] l, input logic [255:0] m, input string tag);
        en        = e;
        seed_load = sl;
        seed      = s;
        len       = l;
        msg       = m;
        @(posedge clk);
        #1;
        if (e) begin
            if (l != 0) model_crc = ref_fold(sl ? s : model_crc, m, l);
            else if (sl) model_crc = s;
        end
        check(tag, crc_o, model_crc);
    endtask

    initial begin
        logic [255:0] m;
        logic [31:0]  r8;
        tests_run = 0;
        fail_cnt  = 0;
        rst       = 1'b1;
        en        = 1'b0;
        seed_load = 1'b0;
        seed      = '0;
        len       = '0;
        msg       = '0;
        model_crc = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        do_reset("reset_value");
        check("reset_const", crc_o, 32'hFFFF_FFFF);

        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 32'h1234_5678, 4'd3, rand_msg(), "idle_en0");
            check("idle_const", crc_o, 32'hFFFF_FFFF);
        end

        cyc(1'b1, 1'b1, 32'h0, 4'd1, 256'h1, "one_dw");
        check("one_dw_const", crc_o, 32'h04C1_1DB7);

        m = rand_msg();
        m[31:0] = 32'h0000_0001;
        cyc(1'b1, 1'b1, 32'h0, 4'd1, m, "one_dw_upper_rand");
        check("one_dw_upper_const", crc_o, 32'h04C1_1DB7);

        cyc(1'b1, 1'b1, 32'hFFFF_FFFF, 4'd1, {224'h0, 32'hFFFF_FFFF}, "all_ones");
        check("all_ones_const", crc_o, 32'h0000_0000);

        m = rand_msg();
        m[63:0] = 64'h0000_0000_0000_0001;
        cyc(1'b1, 1'b1, 32'h0, 4'd2, m, "chain_c1");
        check("chain_c1_const", crc_o, 32'h04C1_1DB7);
        m = rand_msg();
        m[31:0] = 32'h04C1_1DB7;
        cyc(1'b1, 1'b0, 32'hDEAD_BEEF, 4'd1, m, "chain_c2");
        check("chain_c2_const", crc_o, 32'h0000_0000);

        cyc(1'b1, 1'b1, 32'hA5A5_0F0F, 4'd3, rand_msg(), "pre_hold");
        saved_crc = crc_o;
        cyc(1'b1, 1'b0, 32'h1111_2222, 4'd0, rand_msg(), "hold_len0");
        check("hold_len0_same", crc_o, saved_crc);
        cyc(1'b0, 1'b1, 32'h3333_4444, 4'd5, rand_msg(), "hold_en0");
        check("hold_en0_same", crc_o, saved_crc);
        cyc(1'b1, 1'b1, 32'h5555_6666, 4'd0, rand_msg(), "seed_only");
        check("seed_only_const", crc_o, 32'h5555_6666);

        m = rand_msg();
        cyc(1'b1, 1'b1, 32'hCAFE_F00D, 4'd8, m, "len8_ref");
        r8 = crc_o;
        for (int l = 9; l <= 15; l++) begin
            cyc(1'b1, 1'b1, 32'hCAFE_F00D, 4'(l), m, "clamp_model");
            check("clamp_eq_len8", crc_o, r8);
        end

        cyc(1'b1, 1'b1, 32'hFFFF_FFFF, 4'd4,
            {128'h0, 128'h2000_8001_0000_0000_0000_0000_0000_0000}, "equiv_vec");

        cyc(1'b1, 1'b1, 32'h0BAD_CAFE, 4'd6, rand_msg(), "mid_msg");
        do_reset("mid_msg_reset");

        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset("rand_reset");
            end else begin
                cyc(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) == 0),
                    $urandom(), 4'($urandom_range(0, 15)), rand_msg(), "random");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule

// File: doc/crc32_parallel_engine.md
Name: crc32_parallel_engine

Overview:
- Registered, parallel CRC-32 engine for the TL TX data-fragmentation path. It computes the ECRC running value over up to eight 32-bit DWs per clock.
- Each enabled cycle it folds a variable number of DWs (1..8) into the running CRC, or into a freshly loaded seed.
- It is bit-exact with a bit-serial MSB-first LFSR using polynomial 0x04C11DB7. The serial LFSR serves as the verification reference model.

Parameters:
- DATA_WIDTH, 256, message bus width in bits; must be a multiple of 32.
- LENGTH_WIDTH, 4, width of the DW-count input.
- POLY_WIDTH, 32, CRC width; the polynomial is fixed at 32'h04C11DB7.

Ports:
- CRC_i_CLK, input, 1, clock; all state updates on the rising edge.
- CRC_i_RST, input, 1, synchronous active-high reset.
- CRC_i_Message, input, DATA_WIDTH, message data; valid DWs are right-aligned.
- CRC_i_Length, input, LENGTH_WIDTH, number of valid DWs this cycle.
- CRC_i_EN, input, 1, update enable.
- CRC_i_Seed, input, POLY_WIDTH, initial CRC value.
- CRC_i_Seed_Load, input, 1, start a new CRC from CRC_i_Seed this cycle.
- CRC_o_CRC, output, POLY_WIDTH, registered CRC value.

Behaviour:
- Reset: if CRC_i_RST=1 at a clock edge, crc_reg <= 32'hFFFFFFFF. Reset has priority over all other inputs.
- Output: CRC_o_CRC = crc_reg directly.
  - No final XOR, no bit reflection, no byte swap.
  - ECRC inversion and byte mapping are done downstream.
- Effective length:
  - L = CRC_i_Length.
  - Values above DATA_WIDTH/32 (8) clamp to 8.
  - L=0 means no data.
- Valid data occupies CRC_i_Message[L*32-1:0].
  - Processing is MSB first: the first bit processed is bit L*32-1, the last is bit 0.
  - Bits above L*32-1 are ignored and may hold any value.
- Per-bit step (serial reference):
  - fb = crc[31] ^ d.
  - crc = {crc[30:0],1'b0} ^ (fb ? 32'h04C11DB7 : 0).
- Parallel implementation:
  - Compute the next-state function for each possible L (1..8), either as an unrolled/for-loop over the bits or as precomputed XOR matrices.
  - Select the result by L combinationally.
  - The whole L*32-bit block must be absorbed in one cycle.
- Start value: start = CRC_i_Seed_Load ? CRC_i_Seed : crc_reg.
- Update at the rising edge when not in reset:
  - EN=1, L>=1: crc_reg <= step(start, L DWs).
  - EN=1, L=0, Seed_Load=1: crc_reg <= CRC_i_Seed.
  - EN=1, L=0, Seed_Load=0: crc_reg holds.
  - EN=0: crc_reg holds; CRC_i_Seed_Load is ignored.
- Latency: the result appears on CRC_o_CRC one clock after the enabled edge.
- Chaining: consecutive enabled cycles with Seed_Load=0 continue the same CRC. The result must equal one serial pass over the concatenated DWs, in arrival order.
- Algebraic property: for one DW, result = ((start XOR DW) * x^32) mod P.
- Purely combinational, with no pipeline stages beyond crc_reg. There is no handshake or backpressure.
- A reset asserted in the middle of a message discards the partial CRC.

Test Plan:
- Reset -> CRC_o_CRC=FFFFFFFF. After release with EN=0 for 3 cycles -> CRC_o_CRC stays FFFFFFFF.
- EN=1, Seed_Load=1, Seed=0, L=1, Message[31:0]=0000_0001 -> next cycle CRC_o_CRC=04C11DB7. Repeat with Message[255:32] random -> same result.
- EN=1, Seed_Load=1, Seed=FFFFFFFF, L=1, Message[31:0]=FFFFFFFF -> 00000000.
- Chaining:
  - Cycle 1: Seed_Load=1, Seed=0, L=2, Message[63:0]=0000_0000_0000_0001 -> 04C11DB7.
  - Cycle 2: Seed_Load=0, L=1, Message[31:0]=04C11DB7 -> 00000000.
- Hold and clamp:
  - EN=1, L=0, Seed_Load=0 -> value unchanged.
  - L=9..15 -> result equals L=8.
- Equivalence: seed FFFFFFFF, L=4, Message[127:0]=2000_8001_0000_0000_0000_0000_0000_0000. Then 1000 random {seed, L in 0..15, message, Seed_Load} -> CRC_o_CRC matches the bit-serial reference model on every cycle.
